// File: rtl/rob_ring_if.sv
// Port bundle for the reorder buffer: issue, CDB, operand query, commit and flush signals.
interface rob_ring_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic             issue_valid;
   logic [4:0]       issue_rd;
   logic             issue_is_store;
   logic             issue_is_br;
   logic             issue_pred;
   logic [31:0]      issue_pc;
   logic             issue_ready;
   logic [IDX_W-1:0] issue_tag;

   logic             cdb_valid;
   logic [IDX_W-1:0] cdb_tag;
   logic [31:0]      cdb_val;
   logic             cdb_taken;
   logic [31:0]      cdb_target;

   logic [IDX_W-1:0] qry_tag1;
   logic [IDX_W-1:0] qry_tag2;
   logic             qry_rdy1;
   logic             qry_rdy2;
   logic [31:0]      qry_val1;
   logic [31:0]      qry_val2;

   logic             commit_valid;
   logic [4:0]       commit_rd;
   logic [31:0]      commit_val;
   logic [IDX_W-1:0] commit_tag;
   logic             commit_store;
   logic [IDX_W:0]   count;
   logic             jump_wrong;
   logic [31:0]      jump_pc;

   modport slave (
      input  issue_valid, issue_rd, issue_is_store, issue_is_br, issue_pred, issue_pc,
      output issue_ready, issue_tag,
      input  cdb_valid, cdb_tag, cdb_val, cdb_taken, cdb_target,
      input  qry_tag1, qry_tag2,
      output qry_rdy1, qry_rdy2, qry_val1, qry_val2,
      output commit_valid, commit_rd, commit_val, commit_tag, commit_store,
      output count, jump_wrong, jump_pc
   );

   modport master (
      output issue_valid, issue_rd, issue_is_store, issue_is_br, issue_pred, issue_pc,
      input  issue_ready, issue_tag,
      output cdb_valid, cdb_tag, cdb_val, cdb_taken, cdb_target,
      output qry_tag1, qry_tag2,
      input  qry_rdy1, qry_rdy2, qry_val1, qry_val2,
      input  commit_valid, commit_rd, commit_val, commit_tag, commit_store,
      input  count, jump_wrong, jump_pc
   );
endinterface

// File: rtl/rob_ring.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion, in-order retire,
// and mispredict detection at commit that flushes the whole ring one cycle later.
module rob_ring #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdy,
   rob_ring_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef struct packed {
      logic [4:0]  rd;
      logic        store;
      logic        br;
      logic        pred;
      logic [31:0] pc;
      logic [31:0] val;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             commit_valid_q, commit_valid_d, commit_store_q, commit_store_d;
   logic [4:0]       commit_rd_q, commit_rd_d;
   logic [31:0]      commit_val_q, commit_val_d;
   logic [IDX_W-1:0] commit_tag_q, commit_tag_d;
   logic             jump_wrong_q, jump_wrong_d;
   logic [31:0]      jump_pc_q, jump_pc_d;

   logic   issue_ready_c, do_issue_c, do_commit_c, do_cdb_c, mispred_c;
   entry_t head_e_c;

   assign issue_ready_c = (count_q != CNT_W'(DEPTH)) && !jump_wrong_q;
   assign do_issue_c    = rdy && bus.issue_valid && issue_ready_c;
   assign do_commit_c   = rdy && !jump_wrong_q && (count_q != '0)
                          && valid_q[head_q] && ready_q[head_q];
   // A completion aimed at the slot being allocated this cycle belongs to a dead tag.
   assign do_cdb_c      = rdy && !jump_wrong_q && bus.cdb_valid && valid_q[bus.cdb_tag]
                          && !(do_issue_c && (bus.cdb_tag == tail_q));
   assign head_e_c      = ent_q[head_q];
   assign mispred_c     = head_e_c.br && (head_e_c.taken != head_e_c.pred);

   always_comb begin
      ent_d          = ent_q;
      valid_d        = valid_q;
      ready_d        = ready_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = commit_valid_q;
      commit_store_d = commit_store_q;
      commit_rd_d    = commit_rd_q;
      commit_val_d   = commit_val_q;
      commit_tag_d   = commit_tag_q;
      jump_wrong_d   = jump_wrong_q;
      jump_pc_d      = jump_pc_q;
      if (rdy) begin
         commit_valid_d = 1'b0;
         commit_store_d = 1'b0;
         jump_wrong_d   = 1'b0;
         if (jump_wrong_q) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (do_cdb_c) begin
               ent_d[bus.cdb_tag].val    = bus.cdb_val;
               ent_d[bus.cdb_tag].taken  = bus.cdb_taken;
               ent_d[bus.cdb_tag].target = bus.cdb_target;
               ready_d[bus.cdb_tag]      = 1'b1;
            end
            if (do_commit_c) begin
               commit_valid_d  = 1'b1;
               commit_store_d  = head_e_c.store;
               commit_rd_d     = (head_e_c.store || head_e_c.br) ? 5'd0 : head_e_c.rd;
               commit_val_d    = head_e_c.val;
               commit_tag_d    = head_q;
               valid_d[head_q] = 1'b0;
               ready_d[head_q] = 1'b0;
               head_d          = head_q + IDX_W'(1);
               if (mispred_c) begin
                  jump_wrong_d = 1'b1;
                  jump_pc_d    = head_e_c.taken ? head_e_c.target : head_e_c.pc + 32'd4;
               end
            end
            if (do_issue_c) begin
               ent_d[tail_q] = '{rd: bus.issue_rd, store: bus.issue_is_store,
                                 br: bus.issue_is_br, pred: bus.issue_pred,
                                 pc: bus.issue_pc, val: 32'd0, taken: 1'b0, target: 32'd0};
               valid_d[tail_q] = 1'b1;
               ready_d[tail_q] = 1'b0;
               tail_d          = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(do_issue_c) - CNT_W'(do_commit_c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q        <= '0;
         ready_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_store_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         commit_tag_q   <= '0;
         jump_wrong_q   <= 1'b0;
         jump_pc_q      <= '0;
      end else begin
         valid_q        <= valid_d;
         ready_q        <= ready_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_store_q <= commit_store_d;
         commit_rd_q    <= commit_rd_d;
         commit_val_q   <= commit_val_d;
         commit_tag_q   <= commit_tag_d;
         jump_wrong_q   <= jump_wrong_d;
         jump_pc_q      <= jump_pc_d;
      end
   end

   // Payload storage needs no reset: valid/ready bits gate every use of it.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   assign bus.issue_ready  = issue_ready_c;
   assign bus.issue_tag    = tail_q;
   assign bus.qry_rdy1     = valid_q[bus.qry_tag1] && ready_q[bus.qry_tag1];
   assign bus.qry_rdy2     = valid_q[bus.qry_tag2] && ready_q[bus.qry_tag2];
   assign bus.qry_val1     = ent_q[bus.qry_tag1].val;
   assign bus.qry_val2     = ent_q[bus.qry_tag2].val;
   assign bus.commit_valid = commit_valid_q;
   assign bus.commit_rd    = commit_rd_q;
   assign bus.commit_val   = commit_val_q;
   assign bus.commit_tag   = commit_tag_q;
   assign bus.commit_store = commit_store_q;
   assign bus.count        = count_q;
   assign bus.jump_wrong   = jump_wrong_q;
   assign bus.jump_pc      = jump_pc_q;
endmodule

// File: tb/tb_rob_ring.sv
// Directed bench for rob_ring at DEPTH=4 with hand-computed expectations.
module tb_rob_ring;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   rob_ring_if #(.DEPTH(DEPTH)) bus ();
   rob_ring #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.issue_valid    = 1'b0;
      bus.issue_rd       = 5'd0;
      bus.issue_is_store = 1'b0;
      bus.issue_is_br    = 1'b0;
      bus.issue_pred     = 1'b0;
      bus.issue_pc       = 32'd0;
      bus.cdb_valid      = 1'b0;
      bus.cdb_tag        = 2'd0;
      bus.cdb_val        = 32'd0;
      bus.cdb_taken      = 1'b0;
      bus.cdb_target     = 32'd0;
      bus.qry_tag1       = 2'd0;
      bus.qry_tag2       = 2'd0;
   endtask

   task automatic drv_issue(input int rd, input logic st, input logic br, input logic pred,
                            input int pc);
      bus.issue_valid    = 1'b1;
      bus.issue_rd       = 5'(rd);
      bus.issue_is_store = st;
      bus.issue_is_br    = br;
      bus.issue_pred     = pred;
      bus.issue_pc       = 32'(pc);
   endtask

   task automatic drv_cdb(input int tag, input int val, input logic tk, input int tgt);
      bus.cdb_valid  = 1'b1;
      bus.cdb_tag    = 2'(tag);
      bus.cdb_val    = 32'(val);
      bus.cdb_taken  = tk;
      bus.cdb_target = 32'(tgt);
   endtask

   task automatic chk_commit(input string tag, input int t, input int rd, input int val);
      chk({tag, "_valid"}, 32'(bus.commit_valid), 32'd1);
      chk({tag, "_tag"},   32'(bus.commit_tag),   32'(t));
      chk({tag, "_rd"},    32'(bus.commit_rd),    32'(rd));
      chk({tag, "_val"},   bus.commit_val,        32'(val));
   endtask

   initial begin
      idle();
      rst = 1'b1;
      rdy = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_tag",   32'(bus.issue_tag), 32'd0);
      chk("rst_cv",    32'(bus.commit_valid), 32'd0);
      chk("rst_jw",    32'(bus.jump_wrong), 32'd0);
      chk("rst_jpc",   bus.jump_pc, 32'd0);
      chk("rst_ready", 32'(bus.issue_ready), 32'd1);

      // fill the ring, then try one more
      for (int i = 0; i < 4; i++) begin
         drv_issue(i + 1, 1'b0, 1'b0, 1'b0, i * 4);
         chk("fill_tag", 32'(bus.issue_tag), 32'(i));
         tick();
      end
      idle();
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_ready", 32'(bus.issue_ready), 32'd0);
      drv_issue(9, 1'b0, 1'b0, 1'b0, 32'h99);
      tick();
      idle();
      chk("ovf_tag",   32'(bus.issue_tag), 32'd0);
      chk("ovf_count", 32'(bus.count), 32'd4);

      // out-of-order completion, in-order retire
      drv_cdb(2, 32'h30, 1'b0, 0);
      tick();
      chk("ooo_cv_a", 32'(bus.commit_valid), 32'd0);
      drv_cdb(1, 32'h20, 1'b0, 0);
      tick();
      chk("ooo_cv_b", 32'(bus.commit_valid), 32'd0);
      idle();
      bus.qry_tag1 = 2'd2;
      bus.qry_tag2 = 2'd3;
      #1;
      chk("qry_rdy1", 32'(bus.qry_rdy1), 32'd1);
      chk("qry_val1", bus.qry_val1, 32'h30);
      chk("qry_rdy2", 32'(bus.qry_rdy2), 32'd0);
      drv_cdb(0, 32'h10, 1'b0, 0);
      tick();
      chk("ooo_cv_c", 32'(bus.commit_valid), 32'd0);
      idle();
      tick();
      chk_commit("ooo_c0", 0, 1, 32'h10);
      tick();
      chk_commit("ooo_c1", 1, 2, 32'h20);
      tick();
      chk_commit("ooo_c2", 2, 3, 32'h30);
      tick();
      chk("ooo_cv_d",  32'(bus.commit_valid), 32'd0);
      chk("ooo_count", 32'(bus.count), 32'd1);
      drv_cdb(3, 32'h40, 1'b0, 0);
      tick();
      idle();
      tick();
      chk_commit("ooo_c3", 3, 4, 32'h40);
      chk("ooo_empty", 32'(bus.count), 32'd0);

      // completion to an empty slot is dropped
      drv_cdb(0, 32'hdead, 1'b0, 0);
      tick();
      idle();
      #1;
      chk("inv_cdb_rdy", 32'(bus.qry_rdy1), 32'd0);
      chk("inv_cdb_cv",  32'(bus.commit_valid), 32'd0);

      // mispredicted branch at tag 1 flushes younger tag 2
      drv_issue(5, 1'b0, 1'b0, 1'b0, 32'h40);
      tick();
      drv_issue(6, 1'b0, 1'b1, 1'b0, 32'h50);
      tick();
      drv_issue(7, 1'b0, 1'b0, 1'b0, 32'h54);
      tick();
      idle();
      drv_cdb(0, 32'h11, 1'b0, 0);
      tick();
      drv_cdb(1, 0, 1'b1, 32'h100);
      tick();
      chk_commit("mp_c0", 0, 5, 32'h11);
      drv_cdb(2, 32'h22, 1'b0, 0);
      tick();
      idle();
      chk_commit("mp_br", 1, 0, 0);
      chk("mp_jw",    32'(bus.jump_wrong), 32'd1);
      chk("mp_jpc",   bus.jump_pc, 32'h100);
      chk("mp_count", 32'(bus.count), 32'd1);
      chk("mp_ready", 32'(bus.issue_ready), 32'd0);
      drv_issue(8, 1'b0, 1'b0, 1'b0, 32'h58);
      tick();
      idle();
      chk("fl_jw",    32'(bus.jump_wrong), 32'd0);
      chk("fl_cv",    32'(bus.commit_valid), 32'd0);
      chk("fl_count", 32'(bus.count), 32'd0);
      chk("fl_tag",   32'(bus.issue_tag), 32'd0);
      tick();
      chk("fl_cv2", 32'(bus.commit_valid), 32'd0);

      // store retire, then correctly predicted taken branch
      drv_issue(9, 1'b1, 1'b0, 1'b0, 32'h58);
      tick();
      drv_issue(10, 1'b0, 1'b1, 1'b1, 32'h60);
      tick();
      idle();
      drv_cdb(0, 32'haa, 1'b0, 0);
      tick();
      drv_cdb(1, 0, 1'b1, 32'h200);
      tick();
      chk_commit("st", 0, 0, 32'haa);
      chk("st_store", 32'(bus.commit_store), 32'd1);
      idle();
      tick();
      chk_commit("okbr", 1, 0, 0);
      chk("okbr_store", 32'(bus.commit_store), 32'd0);
      chk("okbr_jw",    32'(bus.jump_wrong), 32'd0);
      tick();
      chk("okbr_jw2",   32'(bus.jump_wrong), 32'd0);
      chk("okbr_count", 32'(bus.count), 32'd0);

      // completion racing allocation of the same tag loses
      drv_issue(3, 1'b0, 1'b0, 1'b0, 32'h70);
      drv_cdb(2, 32'h77, 1'b0, 0);
      chk("race_tag", 32'(bus.issue_tag), 32'd2);
      tick();
      idle();
      bus.qry_tag1 = 2'd2;
      #1;
      chk("race_rdy", 32'(bus.qry_rdy1), 32'd0);
      tick();
      chk("race_cv", 32'(bus.commit_valid), 32'd0);
      drv_cdb(2, 32'h78, 1'b0, 0);
      tick();
      idle();
      tick();
      chk_commit("race_c", 2, 3, 32'h78);

      // steady issue/complete/commit with pointer wrap
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wrap_rst_count", 32'(bus.count), 32'd0);
      for (int i = 0; i < 12; i++) begin
         idle();
         if (i < 10) begin
            drv_issue(i + 1, 1'b0, 1'b0, 1'b0, i * 4);
            chk("wrap_tag", 32'(bus.issue_tag), 32'(i % 4));
         end
         if (i >= 1 && i <= 10) drv_cdb((i - 1) % 4, 256 + i - 1, 1'b0, 0);
         tick();
         if (i >= 2) chk_commit("wrap_c", (i - 2) % 4, i - 1, 256 + i - 2);
      end
      idle();
      tick();
      chk("wrap_cv",    32'(bus.commit_valid), 32'd0);
      chk("wrap_count", 32'(bus.count), 32'd0);

      // rdy low freezes everything, including pending completion and issue
      drv_issue(1, 1'b0, 1'b0, 1'b0, 32'h80);
      tick();
      drv_issue(2, 1'b0, 1'b0, 1'b0, 32'h84);
      tick();
      idle();
      chk("hold_pre_count", 32'(bus.count), 32'd2);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drv_cdb(2, 32'h55, 1'b0, 0);
         drv_issue(3, 1'b0, 1'b0, 1'b0, 32'h88);
         bus.qry_tag1 = 2'd2;
         tick();
         chk("hold_count", 32'(bus.count), 32'd2);
         chk("hold_cv",    32'(bus.commit_valid), 32'd0);
         chk("hold_tag",   32'(bus.issue_tag), 32'd0);
         chk("hold_rdy",   32'(bus.qry_rdy1), 32'd0);
      end
      rdy = 1'b1;
      bus.issue_valid = 1'b0;
      tick();
      chk("resume_rdy", 32'(bus.qry_rdy1), 32'd1);
      chk("resume_val", bus.qry_val1, 32'h55);
      idle();
      tick();
      chk_commit("resume_c", 2, 1, 32'h55);
      chk("resume_count", 32'(bus.count), 32'd1);
      rdy = 1'b0;
      tick();
      chk("hold_pulse_cv", 32'(bus.commit_valid), 32'd1);
      chk("hold_pulse_cnt", 32'(bus.count), 32'd1);
      rdy = 1'b1;
      tick();
      chk("release_cv", 32'(bus.commit_valid), 32'd0);

      // reset mid-stream wins even with rdy low
      drv_issue(4, 1'b0, 1'b0, 1'b0, 32'h90);
      tick();
      drv_issue(5, 1'b0, 1'b0, 1'b0, 32'h94);
      tick();
      idle();
      chk("mid_count", 32'(bus.count), 32'd3);
      chk("mid_tag",   32'(bus.issue_tag), 32'd2);
      rdy = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rdy = 1'b1;
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_cv",    32'(bus.commit_valid), 32'd0);
      chk("mid_rst_tag",   32'(bus.issue_tag), 32'd0);
      chk("mid_rst_ready", 32'(bus.issue_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
